// File: rtl/mips_mc_control_pkg.sv
// Shared definitions for the multi-cycle MIPS control sequencer:
// state codes, opcode constants and datapath mux encodings.
package mips_mc_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MADDR  = 4'd2,
        S_MREAD  = 4'd3,
        S_MWB    = 4'd4,
        S_MWRITE = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_AEXEC  = 4'd10,
        S_AWB    = 4'd11,
        S_TRAP   = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_B     = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM: sequences PC/IR/register file/ALU muxes and the
// shared memory over several cycles per instruction, stalling on mem_ready and
// counting retired instructions.
module mips_mc_control
    import mips_mc_control_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter bit          TRAP_ON_ILL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);

    state_e             state_q, state_d;
    logic               retire_now;
    logic [CNT_W-1:0]   retired_q;

    assign state   = state_q;
    assign retired = retired_q;

    // State register with synchronous reset to FETCH.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Next-state logic; retire_now flags a non-wait final cycle of an instruction.
    always_comb begin
        state_d    = state_q;
        retire_now = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MADDR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_AEXEC;
                    default: begin
                        if (TRAP_ON_ILL) begin
                            state_d = S_TRAP;
                        end else begin
                            state_d    = S_FETCH;
                            retire_now = 1'b1;
                        end
                    end
                endcase
            end
            S_MADDR:  state_d = (op == OP_LW) ? S_MREAD : S_MWRITE;
            S_MREAD:  if (mem_ready) state_d = S_MWB;
            S_MWB: begin
                state_d    = S_FETCH;
                retire_now = 1'b1;
            end
            S_MWRITE: begin
                if (mem_ready) begin
                    state_d    = S_FETCH;
                    retire_now = 1'b1;
                end
            end
            S_EXEC:   state_d = S_RWB;
            S_RWB, S_BRANCH, S_JUMP, S_AWB: begin
                state_d    = S_FETCH;
                retire_now = 1'b1;
            end
            S_AEXEC:  state_d = S_AWB;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
    end

    // Moore-style outputs decoded from the current state, all forced low during reset.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUSRCB_B;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;
        illegal_op    = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = ALUSRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: alu_src_b = ALUSRCB_IMMSH;
                S_MADDR, S_AEXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ALUSRCB_IMM;
                end
                S_MREAD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MWRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALUOP_FUNCT;
                end
                S_RWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALUOP_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = PCSRC_JUMP;
                end
                S_AWB:    reg_write  = 1'b1;
                S_TRAP:   illegal_op = 1'b1;
                default: ;
            endcase
        end
    end

    // Retired-instruction counter, wraps modulo 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst)             retired_q <= '0;
        else if (retire_now) retired_q <= retired_q + CNT_W'(1);
    end

endmodule

// File: tb/tb_mips_mc_control.sv
// Scoreboard bench for mips_mc_control: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against two DUT configurations.
module tb_mips_mc_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: CNT_W=32, TRAP_ON_ILL=1
    logic        rst_a = 1'b1, mr_a = 1'b0;
    logic [5:0]  op_a  = 6'd0;
    logic        a_pcw, a_pcwc, a_iord, a_mr, a_mw, a_irw, a_rd, a_m2r, a_rw, a_asa, a_ill;
    logic [1:0]  a_asb, a_aop, a_pcs;
    logic [31:0] a_ret;
    logic [3:0]  a_st;

    // DUT B: CNT_W=4, TRAP_ON_ILL=0
    logic        rst_b = 1'b1, mr_b = 1'b0;
    logic [5:0]  op_b  = 6'd0;
    logic        b_pcw, b_pcwc, b_iord, b_mr, b_mw, b_irw, b_rd, b_m2r, b_rw, b_asa, b_ill;
    logic [1:0]  b_asb, b_aop, b_pcs;
    logic [3:0]  b_ret;
    logic [3:0]  b_st;

    mips_mc_control #(.CNT_W(32), .TRAP_ON_ILL(1'b1)) dut_a (
        .clk(clk), .rst(rst_a), .op(op_a), .mem_ready(mr_a),
        .pc_write(a_pcw), .pc_write_cond(a_pcwc), .i_or_d(a_iord), .mem_read(a_mr),
        .mem_write(a_mw), .ir_write(a_irw), .reg_dst(a_rd), .mem_to_reg(a_m2r),
        .reg_write(a_rw), .alu_src_a(a_asa), .alu_src_b(a_asb), .alu_op(a_aop),
        .pc_source(a_pcs), .illegal_op(a_ill), .retired(a_ret), .state(a_st)
    );

    mips_mc_control #(.CNT_W(4), .TRAP_ON_ILL(1'b0)) dut_b (
        .clk(clk), .rst(rst_b), .op(op_b), .mem_ready(mr_b),
        .pc_write(b_pcw), .pc_write_cond(b_pcwc), .i_or_d(b_iord), .mem_read(b_mr),
        .mem_write(b_mw), .ir_write(b_irw), .reg_dst(b_rd), .mem_to_reg(b_m2r),
        .reg_write(b_rw), .alu_src_a(b_asa), .alu_src_b(b_asb), .alu_op(b_aop),
        .pc_source(b_pcs), .illegal_op(b_ill), .retired(b_ret), .state(b_st)
    );

    logic [16:0] a_ctl, b_ctl;
    assign a_ctl = {a_pcw, a_pcwc, a_iord, a_mr, a_mw, a_irw, a_rd, a_m2r, a_rw, a_asa, a_asb, a_aop, a_pcs, a_ill};
    assign b_ctl = {b_pcw, b_pcwc, b_iord, b_mr, b_mw, b_irw, b_rd, b_m2r, b_rw, b_asa, b_asb, b_aop, b_pcs, b_ill};

    // Control word builder; argument order matches the a_ctl/b_ctl packing.
    function automatic logic [16:0] mk(input logic pcw, pcwc, iord, mr, mw, irw, rd, m2r, rw, asa,
                                       input logic [1:0] asb, aop, pcs, input logic ill);
        return {pcw, pcwc, iord, mr, mw, irw, rd, m2r, rw, asa, asb, aop, pcs, ill};
    endfunction

    //                          pcw pcwc iord mr mw irw rd m2r rw asa asb    aop    pcs    ill
    localparam logic [16:0] C_ZERO   = '0;
    logic [16:0] C_FETCH, C_FWAIT, C_DEC, C_MADDR, C_MREAD, C_MWB, C_MWR, C_EXEC, C_RWB,
                 C_BR, C_J, C_AEX, C_AWB, C_TRAP;
    initial begin
        C_FETCH = mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
        C_FWAIT = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
        C_DEC   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0);
        C_MADDR = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
        C_MREAD = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
        C_MWB   = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0);
        C_MWR   = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
        C_EXEC  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0);
        C_RWB   = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
        C_BR    = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0);
        C_J     = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0);
        C_AEX   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
        C_AWB   = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
        C_TRAP  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1);
    end

    typedef struct {
        bit          sel_b;
        string       name;
        logic [3:0]  st;
        logic [16:0] ctl;
        logic [31:0] ret;
    } exp_t;

    exp_t q[$];
    int unsigned total = 0;
    int unsigned bad   = 0;

    // Monitor: at each negedge, pop every expectation issued for this cycle and compare.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [3:0]  st;
            logic [16:0] ctl;
            logic [31:0] ret;
            e = q.pop_front();
            st  = e.sel_b ? b_st  : a_st;
            ctl = e.sel_b ? b_ctl : a_ctl;
            ret = e.sel_b ? {28'd0, b_ret} : a_ret;
            total++;
            if (st !== e.st) begin
                bad++;
                $display("FAIL %s state: got %0d want %0d", e.name, st, e.st);
            end
            total++;
            if (ctl !== e.ctl) begin
                bad++;
                $display("FAIL %s ctl: got %b want %b", e.name, ctl, e.ctl);
            end
            total++;
            if (ret !== e.ret) begin
                bad++;
                $display("FAIL %s retired: got %0d want %0d", e.name, ret, e.ret);
            end
        end
    end

    // One clock cycle: drive inputs after the edge, then post what the DUT must show this cycle.
    task automatic cyc(input bit sel_b, input logic r, input logic m, input logic [5:0] o,
                       input string name, input logic [3:0] st, input logic [16:0] ctl,
                       input logic [31:0] ret);
        exp_t e;
        @(posedge clk);
        #1;
        if (sel_b) begin rst_b = r; mr_b = m; op_b = o; end
        else       begin rst_a = r; mr_a = m; op_a = o; end
        e.sel_b = sel_b; e.name = name; e.st = st; e.ctl = ctl; e.ret = ret;
        q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        cyc(0, 1, 1, 6'h23, "rst", 4'd0, C_ZERO, 0);
        // lw, no waits: 0,1,2,3,4
        cyc(0, 0, 1, 6'h23, "lw_f",  4'd0, C_FETCH, 0);
        cyc(0, 0, 1, 6'h23, "lw_d",  4'd1, C_DEC,   0);
        cyc(0, 0, 1, 6'h23, "lw_ma", 4'd2, C_MADDR, 0);
        cyc(0, 0, 1, 6'h23, "lw_mr", 4'd3, C_MREAD, 0);
        cyc(0, 0, 1, 6'h23, "lw_wb", 4'd4, C_MWB,   0);
        // R-type with three FETCH wait cycles
        cyc(0, 0, 0, 6'h00, "fw1",   4'd0, C_FWAIT, 1);
        cyc(0, 0, 0, 6'h00, "fw2",   4'd0, C_FWAIT, 1);
        cyc(0, 0, 0, 6'h00, "fw3",   4'd0, C_FWAIT, 1);
        cyc(0, 0, 1, 6'h00, "fw4",   4'd0, C_FETCH, 1);
        cyc(0, 0, 1, 6'h00, "r_d",   4'd1, C_DEC,   1);
        cyc(0, 0, 1, 6'h00, "r_ex",  4'd6, C_EXEC,  1);
        cyc(0, 0, 1, 6'h00, "r_wb",  4'd7, C_RWB,   1);
        // beq
        cyc(0, 0, 1, 6'h04, "beq_f", 4'd0, C_FETCH, 2);
        cyc(0, 0, 1, 6'h04, "beq_d", 4'd1, C_DEC,   2);
        cyc(0, 0, 1, 6'h04, "beq_b", 4'd8, C_BR,    2);
        // sw with one MWRITE wait
        cyc(0, 0, 1, 6'h2B, "sw_f",  4'd0, C_FETCH, 3);
        cyc(0, 0, 1, 6'h2B, "sw_d",  4'd1, C_DEC,   3);
        cyc(0, 0, 1, 6'h2B, "sw_ma", 4'd2, C_MADDR, 3);
        cyc(0, 0, 0, 6'h2B, "sw_w",  4'd5, C_MWR,   3);
        cyc(0, 0, 1, 6'h2B, "sw_mw", 4'd5, C_MWR,   3);
        // addi
        cyc(0, 0, 1, 6'h08, "ai_f",  4'd0, C_FETCH, 4);
        cyc(0, 0, 1, 6'h08, "ai_d",  4'd1, C_DEC,   4);
        cyc(0, 0, 1, 6'h08, "ai_ex", 4'd10, C_AEX,  4);
        cyc(0, 0, 1, 6'h08, "ai_wb", 4'd11, C_AWB,  4);
        // j
        cyc(0, 0, 1, 6'h02, "j_f",   4'd0, C_FETCH, 5);
        cyc(0, 0, 1, 6'h02, "j_d",   4'd1, C_DEC,   5);
        cyc(0, 0, 1, 6'h02, "j_j",   4'd9, C_J,     5);
        // Illegal opcode traps and holds for 20 cycles, counter frozen
        cyc(0, 0, 1, 6'h3F, "il_f",  4'd0, C_FETCH, 6);
        cyc(0, 0, 1, 6'h3F, "il_d",  4'd1, C_DEC,   6);
        for (int i = 0; i < 20; i++)
            cyc(0, 0, logic'(i % 2), 6'(i), "trap", 4'd12, C_TRAP, 6);
        cyc(0, 1, 1, 6'h23, "trap_rst", 4'd12, C_ZERO, 6);
        cyc(0, 0, 0, 6'h23, "post_rst", 4'd0,  C_FWAIT, 0);
        // lw with one MREAD wait
        cyc(0, 0, 1, 6'h23, "lw2_f",  4'd0, C_FETCH, 0);
        cyc(0, 0, 1, 6'h23, "lw2_d",  4'd1, C_DEC,   0);
        cyc(0, 0, 1, 6'h23, "lw2_ma", 4'd2, C_MADDR, 0);
        cyc(0, 0, 0, 6'h23, "lw2_w",  4'd3, C_MREAD, 0);
        cyc(0, 0, 1, 6'h23, "lw2_mr", 4'd3, C_MREAD, 0);
        cyc(0, 0, 1, 6'h23, "lw2_wb", 4'd4, C_MWB,   0);
        // Reset during an MWRITE wait: strobes drop that cycle, instruction lost
        cyc(0, 0, 1, 6'h2B, "swr_f",  4'd0, C_FETCH, 1);
        cyc(0, 0, 1, 6'h2B, "swr_d",  4'd1, C_DEC,   1);
        cyc(0, 0, 1, 6'h2B, "swr_ma", 4'd2, C_MADDR, 1);
        cyc(0, 0, 0, 6'h2B, "swr_w",  4'd5, C_MWR,   1);
        cyc(0, 1, 1, 6'h2B, "swr_rst", 4'd5, C_ZERO, 1);
        cyc(0, 0, 1, 6'h2B, "swr_after", 4'd0, C_FETCH, 0);

        // DUT B: reset, then 16 back-to-back jumps with a 4-bit counter
        cyc(1, 1, 1, 6'h02, "b_rst", 4'd0, C_ZERO, 0);
        for (int i = 0; i < 16; i++) begin
            cyc(1, 0, 1, 6'h02, "bj_f", 4'd0, C_FETCH, 32'(i));
            cyc(1, 0, 1, 6'h02, "bj_d", 4'd1, C_DEC,   32'(i));
            cyc(1, 0, 1, 6'h02, "bj_j", 4'd9, C_J,     32'(i));
        end
        cyc(1, 0, 1, 6'h3F, "bj_wrap", 4'd0, C_FETCH, 0);
        // Illegal opcode retires as a NOP when trapping is disabled
        cyc(1, 0, 1, 6'h3F, "bil_d", 4'd1, C_DEC,   0);
        cyc(1, 0, 1, 6'h02, "bil_f", 4'd0, C_FETCH, 1);

        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
